// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types and constants for the shared adder controller
package adder_share_pkg;

  localparam int SLICE_W  = 8;
  localparam int RESULT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [RESULT_W-1:0] a;
    logic [RESULT_W-1:0] b;
    logic                cin;
    logic                wide;
  } req_t;

endpackage

// File: rtl/add8_core.sv
// rtl/add8_core.sv - combinational 8-bit ripple-carry adder slice
module add8_core
  import adder_share_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - two-requester sequencer/arbiter over one 8-bit adder slice
// Build option: define ADDER_WIDE_OP_EN to honour the wide bit (16-bit adds in two passes).
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int SLICE_W    = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_wide,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_wide,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_sum,
  output logic        rsp_cout
);

`ifdef ADDER_WIDE_OP_EN
  localparam bit WIDE_EN = 1'b1;
`else
  localparam bit WIDE_EN = 1'b0;
`endif

  state_t             state, state_nx;
  req_t               req_q, sel_req;
  logic               id_q;
  logic               last_grant;
  logic               grant;
  logic               accept;
  logic               carry_q;
  logic               cout_q;
  logic [SLICE_W-1:0] sum_lo, sum_hi;
  logic [SLICE_W-1:0] op_a, op_b, slice_s;
  logic               op_c, slice_c;

  // Tie goes to whoever did not win last; a lone valid always wins.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid)
      grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
  end

  assign accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  always_comb begin
    sel_req.a    = grant ? req1_a   : req0_a;
    sel_req.b    = grant ? req1_b   : req0_b;
    sel_req.cin  = grant ? req1_cin : req0_cin;
    sel_req.wide = WIDE_EN & (grant ? req1_wide : req0_wide);
  end

  // Low pass uses the captured carry-in; high pass chains the registered slice carry.
  always_comb begin
    op_a = req_q.a[SLICE_W-1:0];
    op_b = req_q.b[SLICE_W-1:0];
    op_c = req_q.cin;
    if (state == HI) begin
      op_a = req_q.a[RESULT_W-1:SLICE_W];
      op_b = req_q.b[RESULT_W-1:SLICE_W];
      op_c = carry_q;
    end
  end

  add8_core u_add8 (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_c),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LO;
      LO:      state_nx = req_q.wide ? HI : DONE;
      HI:      state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      req_q      <= '0;
      id_q       <= 1'b0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      sum_lo     <= '0;
      sum_hi     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            req_q      <= sel_req;
            id_q       <= grant;
            last_grant <= grant;
          end
        end
        LO: begin
          sum_lo  <= slice_s;
          carry_q <= slice_c;
          if (!req_q.wide) begin
            sum_hi <= '0;
            cout_q <= slice_c;
          end
        end
        HI: begin
          sum_hi <= slice_s;
          cout_q <= slice_c;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_sum   = {sum_hi, sum_lo};
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - self-checking bench for adder_share_ctrl
module tb_adder_share_ctrl;

`ifdef ADDER_WIDE_OP_EN
  localparam bit WIDE_EN = 1'b1;
`else
  localparam bit WIDE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin, req0_wide;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin, req1_wide;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [15:0] rsp_sum;

  int total = 0;
  int bad   = 0;
  int exp_last = 1;

  always #5 clk = ~clk;

  adder_share_ctrl #(.SLICE_W(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_wide(req0_wide),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_wide(req1_wide),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {cout, sum} straight from the arithmetic rules.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic wide);
    logic [16:0] t;
    logic [8:0]  n;
    if (wide && WIDE_EN) begin
      t = {1'b0, a} + {1'b0, b} + 17'(cin);
    end else begin
      n = {1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(cin);
      t = {n[8], 8'h00, n[7:0]};
    end
    return t;
  endfunction

  function automatic int lat_of(input logic wide);
    return (wide && WIDE_EN) ? 3 : 2;
  endfunction

  task automatic set_req(input int n, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic wide);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; req0_wide = wide;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; req1_wide = wide;
    end
  endtask

  // Called at a negedge+1; returns the requester whose ready rose, or -1 on timeout.
  task automatic wait_any_ready(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      if (req0_ready || req1_ready) begin
        who = req1_ready ? 1 : 0;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  // Called #1 after the accept edge; checks latency, result, stall stability, handshake.
  task automatic finish_op(input string tag, input logic [16:0] e, input int id,
                           input int exp_lat, input int stall);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid) chk({tag, "_busy_rdy"}, {req1_ready, req0_ready}, 2'b00);
    end while (!rsp_valid && lat < 10);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_sum"}, rsp_sum, e[15:0]);
    chk({tag, "_cout"}, rsp_cout, e[16]);
    chk({tag, "_id"}, rsp_id, id);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_v"}, {rsp_valid, rsp_id, rsp_cout, rsp_sum}, {1'b1, id[0], e[16], e[15:0]});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_rel"}, rsp_valid, 1'b0);
  endtask

  task automatic run_op(input string tag, input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic wide, input int stall);
    int who;
    @(negedge clk);
    set_req(n, 1'b1, a, b, cin, wide);
    #1;
    wait_any_ready(who);
    chk({tag, "_grant"}, who, n);
    @(posedge clk); #1;
    set_req(n, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    exp_last = n;
    finish_op(tag, model(a, b, cin, wide), n, lat_of(wide), stall);
  endtask

  initial begin
    int          who, w;
    logic [16:0] e;
    logic [15:0] ra [2], rb [2];
    logic        rc [2], rw [2];

    rst = 1'b1; rsp_ready = 1'b0;
    set_req(0, 1'b1, 16'h1, 16'h1, 1'b0, 1'b0);
    set_req(1, 1'b1, 16'h2, 16'h2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, 19'h0);
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed vectors
    run_op("narrow", 0, 16'h00B9, 16'h00A4, 1'b0, 1'b0, 0);
    chk("narrow_const", model(16'h00B9, 16'h00A4, 1'b0, 1'b0), 17'h1005D);
    run_op("wide_carry", 1, 16'h12FF, 16'h0001, 1'b0, 1'b1, 0);
    run_op("wide_ffff", 1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 0);

    // Contention: both valid all the time, alternating winners
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      ra[n] = 16'($urandom); rb[n] = 16'($urandom);
      rc[n] = 1'($urandom);  rw[n] = 1'($urandom);
      set_req(n, 1'b1, ra[n], rb[n], rc[n], rw[n]);
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      wait_any_ready(who);
      w = exp_last ^ 1;
      chk("cont_grant", {req1_ready, req0_ready}, (w == 1) ? 2'b10 : 2'b01);
      chk("cont_seq", w, k % 2);
      e = model(ra[w], rb[w], rc[w], rw[w]);
      @(posedge clk); #1;
      exp_last = w;
      chk("cont_lo_rdy", {req1_ready, req0_ready}, 2'b00);
      ra[w] = 16'($urandom); rb[w] = 16'($urandom);
      rc[w] = 1'($urandom);  rw[w] = 1'($urandom);
      set_req(w, 1'b1, ra[w], rb[w], rc[w], rw[w]);
      who = 0;
      do begin @(negedge clk); who++; end while (!rsp_valid && who < 10);
      chk("cont_id", rsp_id, w);
      chk("cont_res", {rsp_cout, rsp_sum}, e);
      chk("cont_done_rdy", {req1_ready, req0_ready}, 2'b00);
      @(posedge clk);
      @(negedge clk);
    end
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    @(negedge clk);
    if (rsp_valid) begin
      rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    end

    // Backpressure with a waiting requester, then accept exactly one cycle after release
    @(negedge clk);
    ra[0] = 16'($urandom); rb[0] = 16'($urandom);
    set_req(0, 1'b1, ra[0], rb[0], 1'b1, 1'b0);
    #1;
    wait_any_ready(who);
    chk("bp_grant", who, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    ra[1] = 16'($urandom); rb[1] = 16'($urandom);
    set_req(1, 1'b1, ra[1], rb[1], 1'b0, 1'b1);
    e = model(ra[0], rb[0], 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_stable", {rsp_valid, rsp_id, rsp_cout, rsp_sum}, {1'b1, 1'b0, e});
      chk("bp_rdy", {req1_ready, req0_ready}, 2'b00);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_acc", req1_ready, 1'b1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    exp_last = 1;
    finish_op("bp_next", model(ra[1], rb[1], 1'b0, 1'b1), 1, lat_of(1'b1), 0);

    // Reset in the middle of a wide op from requester 0
    run_op("pre_rst", 0, 16'h0101, 16'h0202, 1'b0, 1'b0, 0);
    @(negedge clk);
    set_req(0, 1'b1, 16'hF0F0, 16'h0F10, 1'b0, 1'b1);
    #1;
    wait_any_ready(who);
    chk("mid_grant", who, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
    set_req(1, 1'b1, 16'h0005, 16'h0006, 1'b0, 1'b0);
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_rdy", {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    set_req(0, 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0005, 16'h0006, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 1'b0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mid_tie", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    exp_last = 0;
    finish_op("mid_after", model(16'h0003, 16'h0004, 1'b0, 1'b0), 0, 2, 0);

    // Random single-requester traffic with random stalls
    for (int k = 0; k < 24; k++)
      run_op("rand", $urandom_range(0, 1), 16'($urandom), 16'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
